hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
Sequencing controller for the 5-stage MIPS pipeline. Sits beside the decode-stage control unit and generates every pipeline-register write enable, bubble and flush. It resolves load-use and branch-operand hazards, flushes after taken branches and jumps, and freezes the pipeline while the variable-latency data memory completes an access via a req/ack handshake. A watchdog latches a fault if memory never acknowledges.

Parameters:
TIMEOUT, 16, max wait cycles for dmem_ack before FAULT (1..2^CNT_W-1)
CNT_W, 8, width of wait counter and stall_cycles counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_branch  in  1  ID holds beq or bne
id_jump  in  1  ID holds j
branch_taken  in  1  ID branch comparator result, valid when id_branch=1
idex_memRead  in  1  EX holds a load
idex_regWrite  in  1  EX instruction writes a register
idex_wreg  in  5  EX destination register
exmem_memRead  in  1  MEM holds a load
exmem_memWrite  in  1  MEM holds a store
dmem_ack  in  1  data memory completes access this cycle
dmem_req  out  1  data memory access request
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID cleared to nop at next edge
idex_bubble  out  1  ID/EX loaded with all-zero control
pipe_hold  out  1  ID/EX and EX/MEM hold contents
memwb_bubble  out  1  MEM/WB loaded with all-zero control
fault  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset: synchronous, active-high; reset rst, synchronous, active-high. At the next edge: state=RUN, wait_cnt=0, stall_cycles=0, fault=0. While rst=1, outputs are forced: pc_write=1, ifid_write=1, all others 0.
- States: RUN, MEM_WAIT, FAULT. Outputs are combinational from state and inputs.
- mem_access = exmem_memRead | exmem_memWrite.
- Memory handshake:
  - In RUN or MEM_WAIT, dmem_req = mem_access.
  - When dmem_req=1 and dmem_ack=1 in the same cycle, the access completes and no freeze occurs (zero-wait memory costs nothing).
  - When dmem_req=1 and dmem_ack=0, the cycle is a freeze: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1, ifid_flush=0, idex_bubble=0. The next state is MEM_WAIT and wait_cnt increments.
  - In MEM_WAIT with dmem_ack=1: no freeze, wait_cnt clears, state returns to RUN.
  - Requester rule: dmem_req holds high until ack; ack with req=0 is ignored.
- Timeout: in MEM_WAIT, when wait_cnt==TIMEOUT-1 and dmem_ack=0, the next state is FAULT.
- FAULT: fault=1, dmem_req=0, permanent freeze outputs; only rst exits.
- Hazards are evaluated only when not frozen:
  - Load-use: idex_memRead=1 and idex_wreg!=0 and (idex_wreg==id_rs or idex_wreg==id_rt).
  - Branch-operand: id_branch=1 and idex_regWrite=1 and idex_wreg!=0 and a match on rs/rt. This covers ALU results not yet available to the ID comparator.
  - On any hazard: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0 for that cycle. The hazard clears naturally once the producer leaves EX.
- Control transfer: when not frozen, no hazard, and (id_jump or (id_branch and branch_taken)): ifid_flush=1 for one cycle; pc_write=1, ifid_write=1.
- Priority: FAULT > memory freeze > hazard stall > flush > normal flow (pc_write=ifid_write=1, others 0).
- stall_cycles increments each cycle with pc_write=0 (rst excluded) and saturates at all-ones.
- Reset asserted mid-wait: the next edge returns to RUN with counters cleared; an outstanding dmem_ack is ignored.

Test Plan:
- Load-use: idex_memRead=1, idex_wreg=5, id_rs=5, memory idle -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle (idex_memRead=0) normal flow; stall_cycles=1.
- $zero exempt: the same scenario with idex_wreg=0 -> no stall, pc_write=1.
- Branch: id_branch=1, branch_taken=1, no dependency -> ifid_flush=1 for exactly one cycle. With idex_regWrite=1, idex_wreg=id_rt=3 -> stall first (idex_bubble=1, ifid_flush=0), then flush the following cycle.
- Memory wait: exmem_memRead=1, dmem_ack low for 3 cycles then high -> dmem_req high 4 cycles, pipe_hold=memwb_bubble=1 for 3 cycles, then RUN. A load-use hazard present in the same cycles is masked (idex_bubble=0) until the ack.
- Timeout: TIMEOUT=4, exmem_memWrite=1, ack never -> fault=1 after the 4th unacked cycle; dmem_req=0 and pc_write=0 thereafter; asserting rst clears fault and restores pc_write=1.
- Saturation: CNT_W=3, hold a freeze for 10 cycles -> stall_cycles stops at 7.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller for the 5-stage MIPS core: hazard stalls,
// control-transfer flushes and data-memory wait freezes with a timeout watchdog.
module hazard_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             branch_taken,
  input  logic             idex_memRead,
  input  logic             idex_regWrite,
  input  logic [4:0]       idex_wreg,
  input  logic             exmem_memRead,
  input  logic             exmem_memWrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             memwb_bubble,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic mem_access;
  logic in_fault;
  logic unacked;
  logic src_match;
  logic load_use;
  logic branch_use;
  logic hazard;
  logic ctrl_xfer;

  assign mem_access = exmem_memRead | exmem_memWrite;
  assign in_fault   = (state == FAULT);
  assign unacked    = mem_access & ~dmem_ack & ~in_fault;

  // Writes to $zero never create a real dependency.
  assign src_match  = (idex_wreg != 5'd0) & ((idex_wreg == id_rs) | (idex_wreg == id_rt));
  assign load_use   = idex_memRead & src_match;
  assign branch_use = id_branch & idex_regWrite & src_match;
  assign hazard     = load_use | branch_use;
  assign ctrl_xfer  = id_jump | (id_branch & branch_taken);

  always_comb begin
    dmem_req     = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_hold    = 1'b0;
    memwb_bubble = 1'b0;
    fault        = 1'b0;
    stall_cycles = '0;
    if (!rst) begin
      stall_cycles = stall_cnt;
      if (in_fault) begin
        fault        = 1'b1;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        pipe_hold    = 1'b1;
        memwb_bubble = 1'b1;
      end else begin
        dmem_req = mem_access;
        if (unacked) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          pipe_hold    = 1'b1;
          memwb_bubble = 1'b1;
        end else if (hazard) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (ctrl_xfer) begin
          ifid_flush = 1'b1;
        end
      end
    end
  end

  // wait_cnt counts consecutive unacknowledged request cycles; reaching
  // TIMEOUT of them traps the controller in FAULT until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (!pc_write && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN, MEM_WAIT: begin
          if (unacked) begin
            wait_cnt <= wait_cnt + 1'b1;
            state    <= (wait_cnt == LAST_WAIT) ? FAULT : MEM_WAIT;
          end else begin
            wait_cnt <= '0;
            state    <= RUN;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios then random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, idex_wreg;
  logic             id_branch, id_jump, branch_taken;
  logic             idex_memRead, idex_regWrite;
  logic             exmem_memRead, exmem_memWrite, dmem_ack;
  logic             dmem_req, pc_write, ifid_write, ifid_flush;
  logic             idex_bubble, pipe_hold, memwb_bubble, fault;
  logic [CNT_W-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Model state: consecutive unacked request cycles, sticky fault, stall count.
  int m_wait   = 0;
  bit m_fault  = 0;
  int m_stalls = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch), .id_jump(id_jump),
    .branch_taken(branch_taken), .idex_memRead(idex_memRead),
    .idex_regWrite(idex_regWrite), .idex_wreg(idex_wreg),
    .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_hold(pipe_hold), .memwb_bubble(memwb_bubble), .fault(fault),
    .stall_cycles(stall_cycles)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setIdle();
    rst = 0; id_rs = 0; id_rt = 0; idex_wreg = 0;
    id_branch = 0; id_jump = 0; branch_taken = 0;
    idex_memRead = 0; idex_regWrite = 0;
    exmem_memRead = 0; exmem_memWrite = 0; dmem_ack = 0;
  endtask

  // Runs one clock with the currently driven inputs: checks outputs mid-cycle
  // against the model, then advances the model at the rising edge.
  task automatic applyStimulus();
    bit e_req, e_pc, e_ifid, e_flush, e_bub, e_hold, e_mwb, e_fault;
    bit mem, waiting, dep;
    int e_stall;
    @(negedge clk);
    mem     = exmem_memRead || exmem_memWrite;
    waiting = mem && !dmem_ack;
    dep     = idex_wreg != 0 && (idex_wreg == id_rs || idex_wreg == id_rt);
    {e_req, e_flush, e_bub, e_hold, e_mwb, e_fault} = '0;
    e_pc = 1; e_ifid = 1; e_stall = 0;
    if (!rst) begin
      e_stall = m_stalls;
      if (m_fault) begin
        {e_pc, e_ifid} = 2'b00; {e_hold, e_mwb, e_fault} = 3'b111;
      end else begin
        e_req = mem;
        if (waiting) begin
          {e_pc, e_ifid} = 2'b00; {e_hold, e_mwb} = 2'b11;
        end else if ((idex_memRead && dep) || (id_branch && idex_regWrite && dep)) begin
          {e_pc, e_ifid} = 2'b00; e_bub = 1;
        end else if (id_jump || (id_branch && branch_taken)) begin
          e_flush = 1;
        end
      end
    end
    checkOutput("dmem_req",     dmem_req,     e_req);
    checkOutput("pc_write",     pc_write,     e_pc);
    checkOutput("ifid_write",   ifid_write,   e_ifid);
    checkOutput("ifid_flush",   ifid_flush,   e_flush);
    checkOutput("idex_bubble",  idex_bubble,  e_bub);
    checkOutput("pipe_hold",    pipe_hold,    e_hold);
    checkOutput("memwb_bubble", memwb_bubble, e_mwb);
    checkOutput("fault",        fault,        e_fault);
    checkOutput("stall_cycles", stall_cycles, e_stall);
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_fault = 0; m_stalls = 0;
    end else begin
      if (!e_pc && m_stalls < SAT) m_stalls++;
      if (!m_fault) begin
        if (waiting) begin
          m_wait++;
          if (m_wait >= TIMEOUT) m_fault = 1;
        end else begin
          m_wait = 0;
        end
      end
    end
    #1;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1;
    applyStimulus();
    applyStimulus();
    rst = 0;
  endtask

  initial begin
    bit pending;
    setIdle();
    #1;
    doReset();

    $display("[TB] load-use stall");
    idex_memRead = 1; idex_wreg = 5; id_rs = 5;
    applyStimulus();
    idex_memRead = 0;
    applyStimulus();
    checkOutput("lu_stall_count", stall_cycles, 1);

    $display("[TB] zero register exempt");
    idex_memRead = 1; idex_wreg = 0; id_rs = 0;
    applyStimulus();
    setIdle();

    $display("[TB] branch flush and dependent branch");
    id_branch = 1; branch_taken = 1; id_rs = 1; id_rt = 2;
    applyStimulus();
    id_branch = 0;
    applyStimulus();
    id_branch = 1; idex_regWrite = 1; idex_wreg = 3; id_rt = 3;
    applyStimulus();
    idex_regWrite = 0; idex_wreg = 0;
    applyStimulus();
    setIdle();
    id_jump = 1;
    applyStimulus();
    setIdle();

    $display("[TB] memory wait masking a load-use hazard");
    exmem_memRead = 1; idex_memRead = 1; idex_wreg = 7; id_rt = 7;
    for (int i = 0; i < 3; i++) applyStimulus();
    dmem_ack = 1;
    applyStimulus();
    setIdle();
    applyStimulus();

    $display("[TB] timeout to fault");
    exmem_memWrite = 1;
    for (int i = 0; i < TIMEOUT; i++) applyStimulus();
    checkOutput("to_fault_set", fault, 1);
    checkOutput("to_pc_frozen", pc_write, 0);
    applyStimulus();
    dmem_ack = 1;
    applyStimulus();
    doReset();
    checkOutput("to_fault_clear", fault, 0);
    checkOutput("to_pc_restored", pc_write, 1);

    $display("[TB] stall counter saturation");
    exmem_memWrite = 1;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("sat_stall_count", stall_cycles, SAT);
    doReset();

    $display("[TB] random traffic");
    pending = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < (m_fault ? 25 : 2));
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      idex_wreg = 5'($urandom_range(0, 3));
      id_branch = $urandom_range(0, 3) == 0;
      id_jump = !id_branch && $urandom_range(0, 5) == 0;
      branch_taken = $urandom_range(0, 1) == 1;
      idex_memRead = $urandom_range(0, 2) == 0;
      idex_regWrite = $urandom_range(0, 1) == 1;
      if (!pending) begin
        exmem_memRead = $urandom_range(0, 3) == 0;
        exmem_memWrite = !exmem_memRead && $urandom_range(0, 4) == 0;
      end
      dmem_ack = $urandom_range(0, 99) < 45;
      pending = !rst && (exmem_memRead || exmem_memWrite) && !dmem_ack;
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
